// File: rtl/imm_gen_stage.sv
// Immediate generation stage: decodes the RV immediate at accept time and
// holds results in a two-entry skid buffer with a registered InReady.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] OutTag,
    output logic             ImmErr,
    output logic [ERR_W-1:0] ErrCnt
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } ent_t;

    ent_t             main_q;
    ent_t             skid_q;
    ent_t             new_e;
    logic             main_v;
    logic             skid_v;
    logic             rdy_q;
    logic [ERR_W-1:0] cnt_q;

    logic [31:0]      v32;
    logic             sx;
    logic             bad;
    logic [XLEN-1:0]  imm_w;
    logic             accept;
    logic             xfer;
    logic             unused_instr;

    assign unused_instr = ^Instr[6:0];

    always_comb begin
        v32 = '0;
        sx  = 1'b0;
        bad = 1'b0;
        unique case (ImmSrc)
            3'b000: begin
                v32 = {{20{Instr[31]}}, Instr[31:20]};
                sx  = 1'b1;
            end
            3'b001: begin
                v32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
                sx  = 1'b1;
            end
            3'b010: begin
                v32 = {{19{Instr[31]}}, Instr[31], Instr[7],
                       Instr[30:25], Instr[11:8], 1'b0};
                sx  = 1'b1;
            end
            3'b011: begin
                v32 = {{11{Instr[31]}}, Instr[31], Instr[19:12],
                       Instr[20], Instr[30:21], 1'b0};
                sx  = 1'b1;
            end
            3'b100: begin
                v32 = {Instr[31:12], 12'b0};
                sx  = 1'b1;
            end
            3'b101: begin
                // RV64 shifts use a 6-bit shamt
                if (XLEN == 64) v32 = {26'b0, Instr[25:20]};
                else            v32 = {27'b0, Instr[24:20]};
            end
            3'b110: v32 = {27'b0, Instr[19:15]};
            default: bad = 1'b1;
        endcase
        imm_w       = {XLEN{sx & Instr[31]}};
        imm_w[31:0] = v32;
    end

    assign new_e  = {imm_w, InTag, bad};
    assign accept = InValid & rdy_q;
    assign xfer   = main_v & OutReady;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (xfer) begin
                if (skid_v) begin
                    main_q <= skid_q;
                    skid_v <= 1'b0;
                    rdy_q  <= 1'b1;
                end else if (accept) begin
                    main_q <= new_e;
                end else begin
                    main_v <= 1'b0;
                end
            end else if (accept) begin
                if (main_v) begin
                    skid_q <= new_e;
                    skid_v <= 1'b1;
                    rdy_q  <= 1'b0;
                end else begin
                    main_q <= new_e;
                    main_v <= 1'b1;
                end
            end
            if (accept && bad && cnt_q != '1)
                cnt_q <= cnt_q + ERR_W'(1);
        end
    end

    assign InReady  = rdy_q;
    assign OutValid = main_v;
    assign ImmExt   = main_q.imm;
    assign OutTag   = main_q.tag;
    assign ImmErr   = main_q.err;
    assign ErrCnt   = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus
// and are compared against a queue model of accepted instructions.
module tb_imm_gen_stage;

    logic        clk;
    logic        reset_n;
    logic        InValid;
    logic        OutReady;
    logic [31:0] Instr;
    logic [2:0]  ImmSrc;
    logic [4:0]  InTag;

    logic        ir32, ov32, ie32;
    logic [31:0] imm32;
    logic [4:0]  ot32;
    logic [7:0]  ec32;
    logic        ir64, ov64, ie64;
    logic [63:0] imm64;
    logic [4:0]  ot64;
    logic [7:0]  ec64;

    imm_gen_stage #(.XLEN(32), .TAG_W(5), .ERR_W(8)) u32 (
        .clk(clk), .reset_n(reset_n),
        .InValid(InValid), .InReady(ir32),
        .Instr(Instr), .ImmSrc(ImmSrc), .InTag(InTag),
        .OutValid(ov32), .OutReady(OutReady),
        .ImmExt(imm32), .OutTag(ot32), .ImmErr(ie32), .ErrCnt(ec32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(5), .ERR_W(8)) u64 (
        .clk(clk), .reset_n(reset_n),
        .InValid(InValid), .InReady(ir64),
        .Instr(Instr), .ImmSrc(ImmSrc), .InTag(InTag),
        .OutValid(ov64), .OutReady(OutReady),
        .ImmExt(imm64), .OutTag(ot64), .ImmErr(ie64), .ErrCnt(ec64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        logic [4:0]  tag;
    } ent_t;

    ent_t       q[$];
    logic [4:0] outlog[$];
    int         nerr;
    bit         acc;
    bit         log_on;
    int         checks;
    int         errors;

    // Reference decode from field values with plain integer arithmetic
    function automatic logic [63:0] ref_imm(logic [31:0] ins,
                                            logic [2:0] src, int xlen);
        longint v;
        v = 0;
        case (src)
            3'd0: begin
                v = longint'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
            3'd1: begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (ins[31]) v -= 4096;
            end
            3'd2: begin
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                  + longint'(ins[11:8]) * 2;
                if (ins[31]) v -= 4096;
            end
            3'd3: begin
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                  + longint'(ins[30:21]) * 2;
                if (ins[31]) v -= 1048576;
            end
            3'd4: begin
                v = longint'(ins[30:12]) * 4096;
                if (ins[31]) v -= 64'sh80000000;
            end
            3'd5: v = (xlen == 64) ? longint'(ins[25:20])
                                   : longint'(ins[24:20]);
            3'd6: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    always @(posedge clk) begin
        int sz;
        sz = q.size();
        if (!reset_n) begin
            q.delete();
            nerr = 0;
            acc  = 1'b0;
        end else begin
            acc = InValid && (sz < 2);
            if (OutReady && sz > 0) begin
                if (log_on) outlog.push_back(ot32);
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back('{Instr, ImmSrc, InTag});
                if (ImmSrc == 3'd7) nerr++;
            end
        end
    end

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", name, obs, exp);
            $error("%s differs", name);
        end
    endtask

    task automatic check_all();
        int ecnt;
        ecnt = (nerr > 255) ? 255 : nerr;
        chk("valid32", ov32, q.size() != 0);
        chk("valid64", ov64, q.size() != 0);
        chk("ready32", ir32, q.size() < 2);
        chk("ready64", ir64, q.size() < 2);
        chk("errcnt32", ec32, ecnt);
        chk("errcnt64", ec64, ecnt);
        if (q.size() != 0) begin
            chk("imm32", imm32, ref_imm(q[0].ins, q[0].src, 32));
            chk("imm64", imm64, ref_imm(q[0].ins, q[0].src, 64));
            chk("tag32", ot32, q[0].tag);
            chk("tag64", ot64, q[0].tag);
            chk("err32", ie32, q[0].src == 3'd7);
            chk("err64", ie64, q[0].src == 3'd7);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic offer(logic [31:0] ins, logic [2:0] src, logic [4:0] tag);
        InValid = 1'b1;
        Instr   = ins;
        ImmSrc  = src;
        InTag   = tag;
    endtask

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        log_on   = 1'b0;
        reset_n  = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        Instr    = '0;
        ImmSrc   = '0;
        InTag    = '0;
        repeat (2) cyc();
        chk("rst_imm32", imm32, 0);
        chk("rst_tag32", ot32, 0);
        chk("rst_err32", ie32, 0);
        chk("rst_imm64", imm64, 0);
        reset_n = 1'b1;
        cyc();

        OutReady = 1'b1;
        offer(32'hFFF00093, 3'd0, 5'd7);
        cyc();
        chk("i_valid", ov32, 1);
        chk("i_imm", imm32, 64'hFFFFFFFF);
        chk("i_err", ie32, 0);
        offer(32'hFE000EE3, 3'd2, 5'd8);
        cyc();
        chk("b_imm", imm32, 64'hFFFFFFFC);
        offer(32'h01F0D093, 3'd5, 5'd9);
        cyc();
        chk("sh_imm", imm32, 64'h1F);
        offer(32'h800002B7, 3'd4, 5'd10);
        cyc();
        chk("u64_imm", imm64, 64'hFFFFFFFF80000000);
        InValid = 1'b0;
        repeat (2) cyc();

        OutReady = 1'b0;
        offer(32'h00100093, 3'd0, 5'd1);
        cyc();
        offer(32'h00200093, 3'd0, 5'd2);
        cyc();
        chk("skid_rdy", ir32, 0);
        offer(32'h00300093, 3'd0, 5'd3);
        repeat (2) cyc();
        chk("held_tag", ot32, 1);
        chk("held_rdy", ir32, 0);
        log_on   = 1'b1;
        OutReady = 1'b1;
        for (int i = 0; i < 20 && outlog.size() < 3; i++) begin
            cyc();
            if (acc) InValid = 1'b0;
        end
        log_on = 1'b0;
        chk("order_cnt", outlog.size(), 3);
        for (int i = 0; i < outlog.size() && i < 3; i++)
            chk("order_tag", outlog[i], i + 1);
        InValid = 1'b0;
        repeat (2) cyc();

        for (int i = 0; i < 300; i++) begin
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 3) != 0);
            Instr    = $urandom;
            ImmSrc   = 3'($urandom_range(0, 7));
            InTag    = 5'($urandom);
            cyc();
        end

        OutReady = 1'b1;
        ImmSrc   = 3'd7;
        n = 0;
        for (int i = 0; i < 1000 && n < 300; i++) begin
            InValid = 1'b1;
            Instr   = $urandom;
            InTag   = 5'($urandom);
            cyc();
            if (acc) n++;
        end
        chk("bad_accepts", n, 300);
        InValid = 1'b0;
        cyc();
        chk("sat32", ec32, 255);
        chk("sat64", ec64, 255);
        cyc();

        OutReady = 1'b0;
        offer(32'h12345013, 3'd0, 5'd20);
        cyc();
        offer(32'h00000FFF, 3'd7, 5'd21);
        cyc();
        chk("full_rdy", ir32, 0);
        chk("full_valid", ov32, 1);
        reset_n = 1'b0;
        offer(32'hABCDE037, 3'd4, 5'd22);
        cyc();
        reset_n = 1'b1;
        InValid = 1'b0;
        chk("mrst_valid", ov32, 0);
        chk("mrst_rdy", ir32, 1);
        chk("mrst_cnt", ec32, 0);
        chk("mrst_imm", imm64, 0);
        chk("mrst_tag", ot32, 0);
        OutReady = 1'b1;
        repeat (5) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
